ps2_mouse_init_sequencer: RTL and testbench
===========================================

Name: ps2_mouse_init_sequencer

Overview:
- Host-side command sequencer for the PS/2 mouse link. Drives the byte-level PS/2 transmitter/receiver pair through the power-up command sequence: Reset, BAT/ID check, Set Sample Rate, Enable Data Reporting.
- Handles ACK/resend/error responses, per-step timeouts and retries.
- Once the mouse is in stream mode, hands the link to the packet assembler by asserting Stream_en.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency, used only for documentation and timeout derivation.
- ACK_TIMEOUT, 2_500_000, cycles to wait for an ACK byte (25 ms).
- BAT_TIMEOUT, 75_000_000, cycles to wait for BAT 0xAA after the reset ACK (750 ms).
- MAX_RETRY, 3, resends allowed per step before FAIL.
- SAMPLE_RATE, 8'd100, argument sent after 0xF3.

Ports:
- Clock_100MHz  in  1  system clock.
- Clear  in  1  synchronous active-high reset.
- Start  in  1  one-cycle pulse; begins the sequence from IDLE or FAIL.
- tx_req  out  1  one-cycle pulse; loads tx_byte into the PS/2 transmitter.
- tx_byte  out  8  command/argument byte, stable from tx_req until tx_done or tx_err.
- tx_busy  in  1  transmitter busy; tx_req is issued only when this is 0.
- tx_done  in  1  pulse; byte sent and device line-ACK received.
- tx_err  in  1  pulse; transmitter aborted (no device clock).
- rx_valid  in  1  pulse; rx_byte holds a received byte.
- rx_byte  in  8  received byte.
- Busy  out  1  high in any state other than IDLE, STREAM or FAIL.
- Stream_en  out  1  high only in STREAM.
- Data_reporting_pass  out  1  sticky; set when 0xF4 is ACKed, cleared by Clear or Start.
- Init_fail  out  1  high only in FAIL.
- Fail_code  out  3  0 = none, 1 = timeout, 2 = 0xFC error, 3 = bad BAT, 4 = bad ID, 5 = tx_err retries exhausted.

Behaviour:
- Reset: all outputs 0, state IDLE, step 0, retry 0, timer 0. Clear takes effect on any cycle, mid-transfer included; tx_req drops the next cycle.
- Step table (step index 0..3): 0xFF, 0xF3, SAMPLE_RATE, 0xF4.
- States:
  - IDLE: Start → SEND (step 0).
  - SEND: waits for tx_busy = 0, pulses tx_req for one cycle → WAIT_TX.
  - WAIT_TX: tx_done → WAIT_ACK, timer cleared. tx_err → retry.
  - WAIT_ACK, on rx_valid:
    - 0xFA: step 0 → WAIT_BAT. Step 3 → set Data_reporting_pass, then STREAM. Otherwise step+1 → SEND.
    - 0xFE or any other byte: retry.
    - 0xFC: FAIL, code 2.
  - WAIT_ACK timeout after ACK_TIMEOUT cycles: retry.
  - WAIT_BAT: 0xAA → WAIT_ID. Any other byte → FAIL, code 3. Timeout (BAT_TIMEOUT) → FAIL, code 1.
  - WAIT_ID: 0x00 → step 1, SEND. Other byte → FAIL, code 4. Timeout (ACK_TIMEOUT) → FAIL, code 1.
  - STREAM: ignores rx; Start restarts at step 0.
  - FAIL: holds until Start.
- Retry: if retry < MAX_RETRY, increment retry and → SEND with the same step. Otherwise → FAIL, code 1 (timeout/resend) or code 5 (tx_err).
- The retry counter clears on every step advance.
- Timer: counts cycles while in a WAIT state and clears on each state entry. Timeout fires on the cycle timer == limit − 1.
- Simultaneous rx_valid and timeout on the same cycle: rx_valid wins.
- Start outside IDLE/STREAM/FAIL is ignored.
- rx_valid outside the WAIT states is ignored.

Optional Feature:
- Macro PS2_INTELLIMOUSE_EN.
- Defined: after the 0x00 ID, the steps become 0xF3,200; 0xF3,100; 0xF3,80; 0xF2, then WAIT_ID2. WAIT_ID2 accepts 0x03 (sets output Wheel_present = 1) or 0x00 (Wheel_present = 0); any other ID → FAIL, code 4. The sequence then continues with 0xF3,SAMPLE_RATE; 0xF4.
- Undefined: the Wheel_present port is absent and the 4-step table is unchanged.

Decomposition:
- Shared package: state encoding, the PS/2 command constants (0xFF, 0xF3, 0xF2, 0xF4, 0xFA, 0xFE, 0xFC, 0xAA), and the Fail_code values.
- One natural sub-module: ps2_timeout_timer, a loadable down-counter with clear and an expire pulse.

Test Plan:
- Clean init: after Start, the device model answers FA; AA; 00; FA; FA; FA.
  - Expected tx bytes: FF, F3, 64, F4.
  - End state: Stream_en = 1, Data_reporting_pass = 1, Busy = 0.
- Resend: device returns FE to F3 twice, then FA. Expected: F3 sent 3 times, then the sequence completes normally.
- Error: device returns FC to FF. Expected: Init_fail = 1, Fail_code = 2, no further tx_req.
- Timeout: device is silent after F4. Expected: F4 sent 4 times, ACK_TIMEOUT cycles apart, then Fail_code = 1. Run with ACK_TIMEOUT reduced to 200.
- Bad BAT: device sends FC after the FF ACK. Expected: Fail_code = 3. Then Start restarts at FF and a clean run passes.
- Clear asserted in WAIT_TX of step 2. Expected on the next cycle: all outputs 0 and state IDLE. A subsequent Start resends FF.

Source files
------------

// File: rtl/ps2_mouse_init_sequencer_pkg.sv
// Shared types and PS/2 constants for the mouse init sequencer.
// The PS2_INTELLIMOUSE_EN macro stretches the step table with the wheel-detect knock sequence.
package ps2_mouse_init_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_WAIT_ID2,
    ST_STREAM,
    ST_FAIL
  } seqState_e;

  typedef enum logic [2:0] {
    FAIL_NONE      = 3'd0,
    FAIL_TIMEOUT   = 3'd1,
    FAIL_DEV_ERROR = 3'd2,
    FAIL_BAD_BAT   = 3'd3,
    FAIL_BAD_ID    = 3'd4,
    FAIL_TX_ERR    = 3'd5
  } failCode_e;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ERROR    = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] ID_STANDARD  = 8'h00;
  localparam logic [7:0] ID_WHEEL     = 8'h03;

`ifdef PS2_INTELLIMOUSE_EN
  // Step 7 is the Get-ID command whose ACK leads to the second ID check
  localparam logic [3:0] ID2_STEP  = 4'd7;
  localparam logic [3:0] LAST_STEP = 4'd10;
`else
  localparam logic [3:0] LAST_STEP = 4'd3;
`endif

endpackage

// File: rtl/ps2_timeout_timer.sv
// Loadable down-counter; o_expire is high while enabled and the count has reached zero.
module ps2_timeout_timer #(
  parameter int unsigned W = 32
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_loadValue,
  input  logic         i_enable,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expire = i_enable && (r_count == '0);

endmodule

// File: rtl/ps2_mouse_init_sequencer.sv
// Host-side PS/2 mouse power-up sequencer: Reset, BAT/ID, Set Sample Rate, Enable Reporting.
// Define PS2_INTELLIMOUSE_EN to add the wheel knock sequence and the Wheel_present output.
module ps2_mouse_init_sequencer
  import ps2_mouse_init_sequencer_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned ACK_TIMEOUT = CLK_HZ / 40,
  parameter int unsigned BAT_TIMEOUT = (CLK_HZ / 4) * 3,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [7:0]  SAMPLE_RATE = 8'd100
) (
  input  logic       Clock_100MHz,
  input  logic       Clear,
  input  logic       Start,
  output logic       tx_req,
  output logic [7:0] tx_byte,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic       tx_err,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       Busy,
  output logic       Stream_en,
  output logic       Data_reporting_pass,
  output logic       Init_fail,
  output logic [2:0] Fail_code
`ifdef PS2_INTELLIMOUSE_EN
  , output logic     Wheel_present
`endif
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  seqState_e           r_state, w_nextState;
  logic [3:0]          r_step, w_nextStep;
  logic [RETRY_W-1:0]  r_retry, w_nextRetry;
  failCode_e           r_failCode, w_nextFailCode;
  logic                r_pass, w_nextPass;
  logic                r_txReq, w_nextTxReq;
  logic [7:0]          r_txByte, w_nextTxByte;
  logic [7:0]          w_stepByte;
  logic                w_retryReq, w_retryTxErr;
  logic                w_timerLoad, w_timerEnable, w_timeout;
  logic [31:0]         w_timerLimit;
`ifdef PS2_INTELLIMOUSE_EN
  logic                r_wheel, w_nextWheel;
`endif

  always_comb begin
    w_stepByte = 8'h00;
`ifdef PS2_INTELLIMOUSE_EN
    case (r_step)
      4'd0:                    w_stepByte = CMD_RESET;
      4'd1, 4'd3, 4'd5, 4'd8:  w_stepByte = CMD_SET_RATE;
      4'd2:                    w_stepByte = 8'd200;
      4'd4:                    w_stepByte = 8'd100;
      4'd6:                    w_stepByte = 8'd80;
      4'd7:                    w_stepByte = CMD_GET_ID;
      4'd9:                    w_stepByte = SAMPLE_RATE;
      4'd10:                   w_stepByte = CMD_ENABLE;
      default:                 w_stepByte = 8'h00;
    endcase
`else
    case (r_step)
      4'd0:    w_stepByte = CMD_RESET;
      4'd1:    w_stepByte = CMD_SET_RATE;
      4'd2:    w_stepByte = SAMPLE_RATE;
      4'd3:    w_stepByte = CMD_ENABLE;
      default: w_stepByte = 8'h00;
    endcase
`endif
  end

  // Every state change reloads the timer, so each wait starts from a full window
  assign w_timerLoad   = (w_nextState != r_state);
  assign w_timerLimit  = (w_nextState == ST_WAIT_BAT) ? 32'(BAT_TIMEOUT - 1) : 32'(ACK_TIMEOUT - 1);
  assign w_timerEnable = r_state inside {ST_WAIT_TX, ST_WAIT_ACK, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ID2};

  ps2_timeout_timer #(.W(32)) u_timer (
    .i_clock     (Clock_100MHz),
    .i_reset     (Clear),
    .i_load      (w_timerLoad),
    .i_loadValue (w_timerLimit),
    .i_enable    (w_timerEnable),
    .o_expire    (w_timeout)
  );

  always_comb begin
    w_nextState    = r_state;
    w_nextStep     = r_step;
    w_nextRetry    = r_retry;
    w_nextFailCode = r_failCode;
    w_nextPass     = r_pass;
    w_nextTxReq    = 1'b0;
    w_nextTxByte   = r_txByte;
    w_retryReq     = 1'b0;
    w_retryTxErr   = 1'b0;
`ifdef PS2_INTELLIMOUSE_EN
    w_nextWheel    = r_wheel;
`endif

    case (r_state)
      ST_IDLE, ST_STREAM, ST_FAIL: begin
        if (Start) begin
          w_nextState    = ST_SEND;
          w_nextStep     = 4'd0;
          w_nextRetry    = '0;
          w_nextPass     = 1'b0;
          w_nextFailCode = FAIL_NONE;
`ifdef PS2_INTELLIMOUSE_EN
          w_nextWheel    = 1'b0;
`endif
        end
      end

      ST_SEND: begin
        if (!tx_busy) begin
          w_nextTxReq  = 1'b1;
          w_nextTxByte = w_stepByte;
          w_nextState  = ST_WAIT_TX;
        end
      end

      ST_WAIT_TX: begin
        if (tx_done) begin
          w_nextState = ST_WAIT_ACK;
        end else if (tx_err) begin
          w_retryReq   = 1'b1;
          w_retryTxErr = 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        if (rx_valid) begin
          case (rx_byte)
            RSP_ACK: begin
              if (r_step == 4'd0) begin
                w_nextState = ST_WAIT_BAT;
              end else if (r_step == LAST_STEP) begin
                w_nextPass  = 1'b1;
                w_nextState = ST_STREAM;
`ifdef PS2_INTELLIMOUSE_EN
              end else if (r_step == ID2_STEP) begin
                w_nextState = ST_WAIT_ID2;
`endif
              end else begin
                w_nextStep  = r_step + 4'd1;
                w_nextRetry = '0;
                w_nextState = ST_SEND;
              end
            end
            RSP_ERROR: begin
              w_nextState    = ST_FAIL;
              w_nextFailCode = FAIL_DEV_ERROR;
            end
            default: w_retryReq = 1'b1;
          endcase
        end else if (w_timeout) begin
          w_retryReq = 1'b1;
        end
      end

      ST_WAIT_BAT: begin
        if (rx_valid) begin
          if (rx_byte == RSP_BAT_OK) begin
            w_nextState = ST_WAIT_ID;
          end else begin
            w_nextState    = ST_FAIL;
            w_nextFailCode = FAIL_BAD_BAT;
          end
        end else if (w_timeout) begin
          w_nextState    = ST_FAIL;
          w_nextFailCode = FAIL_TIMEOUT;
        end
      end

      ST_WAIT_ID: begin
        if (rx_valid) begin
          if (rx_byte == ID_STANDARD) begin
            w_nextStep  = 4'd1;
            w_nextRetry = '0;
            w_nextState = ST_SEND;
          end else begin
            w_nextState    = ST_FAIL;
            w_nextFailCode = FAIL_BAD_ID;
          end
        end else if (w_timeout) begin
          w_nextState    = ST_FAIL;
          w_nextFailCode = FAIL_TIMEOUT;
        end
      end

`ifdef PS2_INTELLIMOUSE_EN
      ST_WAIT_ID2: begin
        if (rx_valid) begin
          if ((rx_byte == ID_WHEEL) || (rx_byte == ID_STANDARD)) begin
            w_nextWheel = (rx_byte == ID_WHEEL);
            w_nextStep  = ID2_STEP + 4'd1;
            w_nextRetry = '0;
            w_nextState = ST_SEND;
          end else begin
            w_nextState    = ST_FAIL;
            w_nextFailCode = FAIL_BAD_ID;
          end
        end else if (w_timeout) begin
          w_nextState    = ST_FAIL;
          w_nextFailCode = FAIL_TIMEOUT;
        end
      end
`endif

      default: w_nextState = ST_IDLE;
    endcase

    // Resend, timeout and tx_err all share one retry budget per step
    if (w_retryReq) begin
      if (32'(r_retry) < MAX_RETRY) begin
        w_nextRetry = r_retry + RETRY_W'(1);
        w_nextState = ST_SEND;
      end else begin
        w_nextState    = ST_FAIL;
        w_nextFailCode = w_retryTxErr ? FAIL_TX_ERR : FAIL_TIMEOUT;
      end
    end
  end

  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      r_state    <= ST_IDLE;
      r_step     <= 4'd0;
      r_retry    <= '0;
      r_failCode <= FAIL_NONE;
      r_pass     <= 1'b0;
      r_txReq    <= 1'b0;
      r_txByte   <= 8'h00;
`ifdef PS2_INTELLIMOUSE_EN
      r_wheel    <= 1'b0;
`endif
    end else begin
      r_state    <= w_nextState;
      r_step     <= w_nextStep;
      r_retry    <= w_nextRetry;
      r_failCode <= w_nextFailCode;
      r_pass     <= w_nextPass;
      r_txReq    <= w_nextTxReq;
      r_txByte   <= w_nextTxByte;
`ifdef PS2_INTELLIMOUSE_EN
      r_wheel    <= w_nextWheel;
`endif
    end
  end

  assign tx_req              = r_txReq;
  assign tx_byte             = r_txByte;
  assign Busy                = !(r_state inside {ST_IDLE, ST_STREAM, ST_FAIL});
  assign Stream_en           = (r_state == ST_STREAM);
  assign Data_reporting_pass = r_pass;
  assign Init_fail           = (r_state == ST_FAIL);
  assign Fail_code           = r_failCode;
`ifdef PS2_INTELLIMOUSE_EN
  assign Wheel_present       = r_wheel;
`endif

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Directed bench for the PS/2 mouse init sequencer: a byte-level transmitter model
// pops expected command bytes from a scoreboard queue as the sequencer issues them.
module tb_ps2_mouse_init_sequencer;

  localparam int unsigned ACK_T = 200;
  localparam int unsigned BAT_T = 1000;

  logic       clock = 1'b0;
  logic       Clear, Start;
  logic       tx_req;
  logic [7:0] tx_byte;
  logic       tx_busy, tx_done, tx_err;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       Busy, Stream_en, Data_reporting_pass, Init_fail;
  logic [2:0] Fail_code;

  int         nCompared   = 0;
  int         nMismatched = 0;
  logic [7:0] txQ[$];
  int         expDone       = 0;
  int         txDoneCount   = 0;
  int         txReqCount    = 0;
  int         cycle         = 0;
  int         lastDoneCycle = 0;
  int         lastGap       = 0;
  bit         errMode       = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  ps2_mouse_init_sequencer #(
    .ACK_TIMEOUT (ACK_T),
    .BAT_TIMEOUT (BAT_T),
    .MAX_RETRY   (3),
    .SAMPLE_RATE (8'd100)
  ) dut (
    .Clock_100MHz        (clock),
    .Clear               (Clear),
    .Start               (Start),
    .tx_req              (tx_req),
    .tx_byte             (tx_byte),
    .tx_busy             (tx_busy),
    .tx_done             (tx_done),
    .tx_err              (tx_err),
    .rx_valid            (rx_valid),
    .rx_byte             (rx_byte),
    .Busy                (Busy),
    .Stream_en           (Stream_en),
    .Data_reporting_pass (Data_reporting_pass),
    .Init_fail           (Init_fail),
    .Fail_code           (Fail_code)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Transmitter model: every tx_req is checked against the scoreboard, then
  // completes after a few busy cycles with tx_done (or tx_err in errMode)
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    tx_err  = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_req === 1'b1) begin
        txReqCount++;
        lastGap = cycle - lastDoneCycle;
        checkOutput("tx_expected_pending", 32'(txQ.size() != 0), 1);
        if (txQ.size() != 0) checkOutput("tx_byte", tx_byte, txQ.pop_front());
        tx_busy = 1'b1;
        repeat (4) @(negedge clock);
        if (errMode) tx_err = 1'b1;
        else         tx_done = 1'b1;
        lastDoneCycle = cycle;
        @(negedge clock);
        tx_done = 1'b0;
        tx_err  = 1'b0;
        tx_busy = 1'b0;
        txDoneCount++;
      end
    end
  end

  task automatic applyStimulus();
    @(negedge clock);
    Start = 1'b1;
    @(negedge clock);
    Start = 1'b0;
  endtask

  task automatic pushExp(input logic [7:0] b);
    txQ.push_back(b);
    expDone++;
  endtask

  task automatic waitTx(input string tag);
    int k = 0;
    while (txDoneCount < expDone && k < 3000) begin
      @(negedge clock);
      k++;
    end
    checkOutput(tag, 32'(txDoneCount >= expDone), 1);
  endtask

  task automatic deviceSend(input logic [7:0] b);
    @(negedge clock);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic waitFail(input string tag);
    int k = 0;
    while (Init_fail !== 1'b1 && k < 1000) begin
      @(negedge clock);
      k++;
    end
    checkOutput(tag, 32'(Init_fail), 1);
  endtask

  // Drives the sequence up to the ACK-less point just after 0xF4 went out
  task automatic runToF4(input int f3Naks);
    applyStimulus();
    pushExp(8'hFF);
    waitTx("tx_reset_cmd");
    deviceSend(8'hFA);
    deviceSend(8'hAA);
    pushExp(8'hF3);
    deviceSend(8'h00);
    waitTx("tx_set_rate_cmd");
    for (int i = 0; i < f3Naks; i++) begin
      pushExp(8'hF3);
      deviceSend(8'hFE);
      waitTx("tx_set_rate_resend");
    end
    pushExp(8'h64);
    deviceSend(8'hFA);
    waitTx("tx_rate_arg");
    pushExp(8'hF4);
    deviceSend(8'hFA);
    waitTx("tx_enable_cmd");
  endtask

  task automatic cleanRun(input int f3Naks);
    runToF4(f3Naks);
    deviceSend(8'hFA);
    @(negedge clock);
    checkOutput("stream_en", 32'(Stream_en), 1);
    checkOutput("data_reporting_pass", 32'(Data_reporting_pass), 1);
    checkOutput("busy_in_stream", 32'(Busy), 0);
    checkOutput("init_fail_clean", 32'(Init_fail), 0);
    checkOutput("fail_code_clean", 32'(Fail_code), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snapshot;
    int k;

    Clear    = 1'b1;
    Start    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (3) @(negedge clock);
    checkOutput("reset_tx_req", 32'(tx_req), 0);
    checkOutput("reset_tx_byte", 32'(tx_byte), 0);
    checkOutput("reset_busy", 32'(Busy), 0);
    checkOutput("reset_stream_en", 32'(Stream_en), 0);
    checkOutput("reset_pass", 32'(Data_reporting_pass), 0);
    checkOutput("reset_init_fail", 32'(Init_fail), 0);
    checkOutput("reset_fail_code", 32'(Fail_code), 0);
    Clear = 1'b0;

    $display("[TB] clean init");
    cleanRun(0);

    $display("[TB] resend on set-rate");
    cleanRun(2);

    $display("[TB] device error on reset");
    applyStimulus();
    checkOutput("start_clears_pass", 32'(Data_reporting_pass), 0);
    checkOutput("start_leaves_stream", 32'(Stream_en), 0);
    checkOutput("busy_after_start", 32'(Busy), 1);
    pushExp(8'hFF);
    waitTx("tx_reset_before_fc");
    deviceSend(8'hFC);
    checkOutput("fc_init_fail", 32'(Init_fail), 1);
    checkOutput("fc_fail_code", 32'(Fail_code), 2);
    checkOutput("fc_busy", 32'(Busy), 0);
    snapshot = txReqCount;
    repeat (50) @(negedge clock);
    checkOutput("fc_no_more_tx", txReqCount, snapshot);

    $display("[TB] silent device after enable");
    runToF4(0);
    for (int i = 0; i < 3; i++) begin
      pushExp(8'hF4);
      waitTx("tx_enable_retry");
      checkOutput("retry_gap_in_window", 32'((lastGap >= int'(ACK_T)) && (lastGap <= int'(ACK_T) + 3)), 1);
    end
    waitFail("timeout_reaches_fail");
    checkOutput("timeout_fail_code", 32'(Fail_code), 1);
    checkOutput("timeout_no_pass", 32'(Data_reporting_pass), 0);

    $display("[TB] bad BAT then recovery");
    applyStimulus();
    pushExp(8'hFF);
    waitTx("tx_reset_before_bad_bat");
    deviceSend(8'hFA);
    deviceSend(8'hFC);
    checkOutput("bad_bat_init_fail", 32'(Init_fail), 1);
    checkOutput("bad_bat_fail_code", 32'(Fail_code), 3);
    cleanRun(0);

    $display("[TB] transmitter errors exhaust retries");
    errMode = 1'b1;
    applyStimulus();
    for (int i = 0; i < 4; i++) pushExp(8'hFF);
    waitTx("tx_err_attempts");
    waitFail("tx_err_reaches_fail");
    checkOutput("tx_err_fail_code", 32'(Fail_code), 5);
    errMode = 1'b0;

    $display("[TB] clear during rate-argument transfer");
    applyStimulus();
    pushExp(8'hFF);
    waitTx("tx_reset_before_clear");
    deviceSend(8'hFA);
    deviceSend(8'hAA);
    pushExp(8'hF3);
    deviceSend(8'h00);
    waitTx("tx_set_rate_before_clear");
    pushExp(8'h64);
    snapshot = txReqCount;
    deviceSend(8'hFA);
    k = 0;
    while (txReqCount == snapshot && k < 100) begin
      @(negedge clock);
      k++;
    end
    checkOutput("clear_reached_step2_tx", 32'(txReqCount > snapshot), 1);
    Clear = 1'b1;
    @(negedge clock);
    checkOutput("clear_tx_req", 32'(tx_req), 0);
    checkOutput("clear_tx_byte", 32'(tx_byte), 0);
    checkOutput("clear_busy", 32'(Busy), 0);
    checkOutput("clear_stream_en", 32'(Stream_en), 0);
    checkOutput("clear_init_fail", 32'(Init_fail), 0);
    checkOutput("clear_fail_code", 32'(Fail_code), 0);
    Clear = 1'b0;
    waitTx("tx_drain_after_clear");
    applyStimulus();
    pushExp(8'hFF);
    waitTx("tx_reset_after_clear");
    checkOutput("busy_after_restart", 32'(Busy), 1);

    repeat (5) @(negedge clock);
    checkOutput("scoreboard_drained", txQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
